gen_seq: RTL and testbench

- Sequencer that drives the table read side of the arbitrary signal generator.
- Owns the run/arm/trigger control state and the fixed-point table pointer (CWM.CWF), covering both continuous/periodic and burst modes.
- Emits one table address per accepted stream beat, plus a data-enable flag and status/event pulses.
- Sits between the register bank (control/config registers) and the table RAM + amplitude/offset datapath.

---
 rtl/gen_seq_if.sv | 13 +
 rtl/gen_seq.sv | 151 +++++++++++++++
 tb/tb_gen_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_seq_if.sv
// Table read stream between the sequencer and the table RAM / amplitude datapath.
interface gen_seq_if #(
    parameter int CWM = 14
);
    logic [CWM-1:0] ptr;
    logic           vld;
    logic           rdy;
    logic           ena;
    logic           lst;

    modport master (output ptr, vld, ena, lst, input rdy);
    modport slave  (input ptr, vld, ena, lst, output rdy);
endinterface

// File: rtl/gen_seq.sv
// Signal generator table sequencer: run/arm/trigger control, fixed-point table
// pointer, and burst repetition/period accounting.
module gen_seq #(
    parameter int CWM = 14,
    parameter int CWF = 16,
    parameter int CWR = 14,
    parameter int CWL = 32,
    parameter int CWN = 16,
    parameter int TN  = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               ctl_rst,
    input  logic               ctl_str,
    input  logic               ctl_stp,
    input  logic               ctl_swt,
    input  logic [TN-1:0]      trg,
    input  logic [TN-1:0]      cfg_tmsk,
    input  logic               cfg_ben,
    input  logic [CWM+CWF-1:0] cfg_size,
    input  logic [CWM+CWF-1:0] cfg_offs,
    input  logic [CWM+CWF-1:0] cfg_step,
    input  logic [CWR-1:0]     cfg_bdr,
    input  logic [CWL-1:0]     cfg_bdl,
    input  logic [CWL-1:0]     cfg_bpl,
    input  logic [CWN-1:0]     cfg_bpn,
    gen_seq_if.master          tbl,
    output logic               sts_run,
    output logic               sts_arm,
    output logic               evt_trg,
    output logic               evt_end
);
    localparam int W = CWM + CWF;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, PAUSE} state_t;

    state_t         state, state_n;
    logic [W-1:0]   acc, acc_n, acc_step;
    logic [W:0]     sum;
    logic [CWL-1:0] d, d_n, p, p_n;
    logic [CWR-1:0] r, r_n;
    logic [CWN-1:0] n, n_n;
    logic           trg_n, end_n, accept, trig;
    logic           data_last, data_done, p_full, period_end, seq_end;

    // Modular step: wrap by subtracting the table length, keeping the fraction.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, cfg_step} + (W+1)'(1);
        if (sum > {1'b0, cfg_size})
            acc_step = W'(sum - {1'b0, cfg_size} - (W+1)'(1));
        else
            acc_step = sum[W-1:0];
    end

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        d_n        = d;
        r_n        = r;
        p_n        = p;
        n_n        = n;
        trg_n      = 1'b0;
        end_n      = 1'b0;
        accept     = 1'b0;
        trig       = ctl_swt | (|(trg & cfg_tmsk));
        data_last  = (d == cfg_bdl);
        data_done  = data_last && (r == cfg_bdr);
        p_full     = (p >= cfg_bpl);
        period_end = (state == RUN && cfg_ben && data_done && p_full) ||
                     (state == PAUSE && p_full);
        seq_end    = period_end && (n == cfg_bpn);

        if (ctl_stp) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (ctl_str) begin
                           if (trig) accept = 1'b1;
                           else      state_n = ARMED;
                       end
                ARMED: if (trig) accept = 1'b1;
                RUN, PAUSE: if (tbl.rdy) begin
                    p_n = p + CWL'(1);
                    if (period_end) begin
                        n_n     = n + CWN'(1);
                        r_n     = '0;
                        d_n     = '0;
                        p_n     = '0;
                        acc_n   = cfg_offs;
                        state_n = seq_end ? IDLE : RUN;
                        end_n   = seq_end;
                    end else if (state == RUN) begin
                        if (!cfg_ben) begin
                            acc_n = acc_step;
                            p_n   = p;
                        end else if (data_done) begin
                            state_n = PAUSE;
                        end else if (data_last) begin
                            d_n   = '0;
                            r_n   = r + CWR'(1);
                            acc_n = cfg_offs;
                        end else begin
                            d_n   = d + CWL'(1);
                            acc_n = acc_step;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (accept) begin
            state_n = RUN;
            trg_n   = 1'b1;
            acc_n   = cfg_offs;
            d_n     = '0;
            r_n     = '0;
            p_n     = '0;
            n_n     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || ctl_rst) begin
            state   <= IDLE;
            acc     <= '0;
            d       <= '0;
            r       <= '0;
            p       <= '0;
            n       <= '0;
            evt_trg <= 1'b0;
            evt_end <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            d       <= d_n;
            r       <= r_n;
            p       <= p_n;
            n       <= n_n;
            evt_trg <= trg_n;
            evt_end <= end_n;
        end
    end

    assign tbl.ptr = acc[W-1:CWF];
    assign tbl.vld = (state == RUN) || (state == PAUSE);
    assign tbl.ena = (state == RUN);
    assign tbl.lst = seq_end;
    assign sts_run = (state == RUN) || (state == PAUSE);
    assign sts_arm = (state == ARMED);
endmodule

// File: tb/tb_gen_seq.sv
// Scoreboard bench for gen_seq: a beat-list reference model feeds a queue that a
// negedge monitor consumes whenever the DUT presents a sample.
module tb_gen_seq;
    localparam int CWM = 14, CWF = 16, CWR = 14, CWL = 32, CWN = 16, TN = 1;
    localparam int W = CWM + CWF;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic ctl_rst = 1'b0, ctl_str = 1'b0, ctl_stp = 1'b0, ctl_swt = 1'b0;
    logic [TN-1:0] trg = '0, cfg_tmsk = '0;
    logic cfg_ben = 1'b0;
    logic [W-1:0] cfg_size = '0, cfg_offs = '0, cfg_step = '0;
    logic [CWR-1:0] cfg_bdr = '0;
    logic [CWL-1:0] cfg_bdl = '0, cfg_bpl = '0;
    logic [CWN-1:0] cfg_bpn = '0;
    logic sts_run, sts_arm, evt_trg, evt_end;

    gen_seq_if #(.CWM(CWM)) bus ();

    gen_seq #(.CWM(CWM), .CWF(CWF), .CWR(CWR), .CWL(CWL), .CWN(CWN), .TN(TN)) dut (
        .clk(clk), .rstn(rstn), .ctl_rst(ctl_rst), .ctl_str(ctl_str),
        .ctl_stp(ctl_stp), .ctl_swt(ctl_swt), .trg(trg), .cfg_tmsk(cfg_tmsk),
        .cfg_ben(cfg_ben), .cfg_size(cfg_size), .cfg_offs(cfg_offs),
        .cfg_step(cfg_step), .cfg_bdr(cfg_bdr), .cfg_bdl(cfg_bdl),
        .cfg_bpl(cfg_bpl), .cfg_bpn(cfg_bpn), .tbl(bus), .sts_run(sts_run),
        .sts_arm(sts_arm), .evt_trg(evt_trg), .evt_end(evt_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint ptr;
        bit     ena;
        bit     lst;
    } exp_t;

    exp_t q[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   beats = 0;
    bit   end_due = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name, input int got, input int want);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out, got %0d, expected %0d", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pointer advance on the fixed-point table circle.
    function automatic longint nstep(input longint a, input longint s, input longint sz);
        longint nx = a + s + 1;
        return (nx > sz) ? nx - sz - 1 : nx;
    endfunction

    task automatic push(input longint ptr, input bit ena);
        exp_t e;
        e.ptr = ptr;
        e.ena = ena;
        e.lst = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_cont(input longint offs, input longint step, input longint size, input int cnt);
        longint a = offs;
        for (int i = 0; i < cnt; i++) begin
            push(a >> CWF, 1'b1);
            a = nstep(a, step, size);
        end
    endtask

    task automatic push_burst(input longint offs, input longint step, input longint size,
                              input int bdr, input int bdl, input int bpl, input int bpn);
        longint a;
        int cnt;
        for (int per = 0; per <= bpn; per++) begin
            cnt = 0;
            for (int rep = 0; rep <= bdr; rep++) begin
                a = offs;
                for (int i = 0; i <= bdl; i++) begin
                    push(a >> CWF, 1'b1);
                    a = nstep(a, step, size);
                    cnt++;
                end
            end
            for (int k = cnt; k <= bpl; k++) push(0, 1'b0);
        end
        q[q.size()-1].lst = 1'b1;
    endtask

    task automatic set_cfg(input bit ben, input longint size, input longint offs, input longint step,
                           input int bdr, input int bdl, input int bpl, input int bpn);
        cfg_ben  = ben;
        cfg_size = W'(size);
        cfg_offs = W'(offs);
        cfg_step = W'(step);
        cfg_bdr  = CWR'(bdr);
        cfg_bdl  = CWL'(bdl);
        cfg_bpl  = CWL'(bpl);
        cfg_bpn  = CWN'(bpn);
    endtask

    task automatic wait_beats(input int want, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (beats >= want) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_timeout("wait_beats", beats, want);
    endtask

    task automatic run_until_idle(input int budget, input bit rnd);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rnd) bus.rdy = ($urandom_range(0, 3) != 0);
            tick();
            if (!sts_run && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        bus.rdy = 1'b1;
        if (!ok) fail_timeout("run_until_idle_pending", q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ptr"}, bus.ptr, 0);
        chk({tag, "_vld"}, bus.vld, 0);
        chk({tag, "_ena"}, bus.ena, 0);
        chk({tag, "_lst"}, bus.lst, 0);
        chk({tag, "_sts_run"}, sts_run, 0);
        chk({tag, "_sts_arm"}, sts_arm, 0);
        chk({tag, "_evt_trg"}, evt_trg, 0);
        chk({tag, "_evt_end"}, evt_end, 0);
    endtask

    // Monitor: the presented beat must match the queue head (also while stalled);
    // evt_end must follow the accepted last beat by exactly one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) chk("evt_end", evt_end, end_due);
            end_due = 1'b0;
            if (bus.vld && q.size() > 0) begin
                chk("beat_ena", bus.ena, q[0].ena);
                chk("beat_lst", bus.lst, q[0].lst);
                if (q[0].ena) chk("beat_ptr", bus.ptr, q[0].ptr);
                if (bus.rdy) begin
                    end_due = q[0].lst;
                    void'(q.pop_front());
                    beats++;
                end
            end else if (bus.vld && bus.rdy) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_beat: got beat ptr=%0d ena=%0d, expected no beat",
                         bus.ptr, bus.ena);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        longint sz, of, st;
        bit found;
        bus.rdy = 1'b1;
        repeat (4) tick();
        rstn = 1'b1;
        tick();
        check_all_zero("reset");
        ctl_swt = 1'b1; tick(); ctl_swt = 1'b0;
        chk("idle_swt_evt_trg", evt_trg, 0);
        chk("idle_swt_sts_run", sts_run, 0);

        // Continuous, integer step over an 8-entry table
        set_cfg(0, (8 << 16) - 1, 0, 65535, 0, 0, 0, 0);
        push_cont(0, 65535, (8 << 16) - 1, 22);
        beats = 0;
        ctl_str = 1'b1; tick(); ctl_str = 1'b0;
        chk("cont_armed", sts_arm, 1);
        chk("cont_armed_vld", bus.vld, 0);
        ctl_swt = 1'b1; tick(); ctl_swt = 1'b0;
        chk("cont_evt_trg", evt_trg, 1);
        chk("cont_sts_run", sts_run, 1);
        wait_beats(22, 200);
        ctl_stp = 1'b1; bus.rdy = 1'b0; tick(); ctl_stp = 1'b0;
        chk("cont_stop_vld", bus.vld, 0);
        chk("cont_stop_run", sts_run, 0);
        bus.rdy = 1'b1;
        ctl_swt = 1'b1; tick(); ctl_swt = 1'b0;
        chk("cont_post_swt_evt", evt_trg, 0);
        chk("cont_post_swt_vld", bus.vld, 0);
        chk("cont_queue_left", q.size(), 0);

        // Offset start and half-sample step; start and trigger together
        set_cfg(0, (8 << 16) - 1, 4 << 16, 32767, 0, 0, 0, 0);
        push_cont(4 << 16, 32767, (8 << 16) - 1, 10);
        beats = 0;
        ctl_str = 1'b1; ctl_swt = 1'b1; tick(); ctl_str = 1'b0; ctl_swt = 1'b0;
        chk("frac_evt_trg", evt_trg, 1);
        chk("frac_sts_run", sts_run, 1);
        wait_beats(10, 200);
        ctl_stp = 1'b1; bus.rdy = 1'b0; tick(); ctl_stp = 1'b0; bus.rdy = 1'b1;
        chk("frac_stop_vld", bus.vld, 0);
        chk("frac_queue_left", q.size(), 0);

        // Burst with a 3-cycle stall during data
        set_cfg(1, (8 << 16) - 1, 0, 65535, 1, 2, 7, 1);
        push_burst(0, 65535, (8 << 16) - 1, 1, 2, 7, 1);
        beats = 0;
        ctl_str = 1'b1; tick(); ctl_str = 1'b0;
        ctl_swt = 1'b1; tick(); ctl_swt = 1'b0;
        chk("burst_evt_trg", evt_trg, 1);
        wait_beats(2, 100);
        bus.rdy = 1'b0;
        repeat (3) tick();
        bus.rdy = 1'b1;
        run_until_idle(200, 1'b0);
        chk("burst_beats", beats, 16);
        chk("burst_idle_run", sts_run, 0);
        chk("burst_idle_arm", sts_arm, 0);

        // Stop and trigger together while armed: stop wins
        ctl_str = 1'b1; tick(); ctl_str = 1'b0;
        chk("prio_armed", sts_arm, 1);
        ctl_stp = 1'b1; ctl_swt = 1'b1; tick(); ctl_stp = 1'b0; ctl_swt = 1'b0;
        chk("prio_stp_arm", sts_arm, 0);
        chk("prio_stp_run", sts_run, 0);
        chk("prio_stp_evt", evt_trg, 0);

        // Hardware trigger: masked, then enabled
        ctl_str = 1'b1; tick(); ctl_str = 1'b0;
        trg = '1; cfg_tmsk = '0; tick();
        chk("hw_masked_arm", sts_arm, 1);
        chk("hw_masked_evt", evt_trg, 0);
        push_burst(0, 65535, (8 << 16) - 1, 1, 2, 7, 1);
        cfg_tmsk = '1; tick(); trg = '0; cfg_tmsk = '0;
        chk("hw_evt_trg", evt_trg, 1);
        chk("hw_sts_run", sts_run, 1);
        run_until_idle(400, 1'b1);

        // Software reset while pausing
        push_burst(0, 65535, (8 << 16) - 1, 1, 2, 7, 1);
        ctl_str = 1'b1; ctl_swt = 1'b1; tick(); ctl_str = 1'b0; ctl_swt = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.vld && !bus.ena) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) fail_timeout("reach_pause", 0, 1);
        ctl_rst = 1'b1; tick(); ctl_rst = 1'b0;
        check_all_zero("swrst");
        q.delete();

        // Randomized burst configurations with random backpressure
        for (int t = 0; t < 8; t++) begin
            sz = (longint'($urandom_range(1, 40)) << 16) | longint'($urandom_range(0, 65535));
            of = longint'($urandom_range(0, 32'(sz)));
            st = longint'($urandom_range(0, 3 << 16));
            set_cfg(1, sz, of, st, int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            push_burst(of, st, sz, int'(cfg_bdr), int'(cfg_bdl), int'(cfg_bpl), int'(cfg_bpn));
            ctl_str = 1'b1; ctl_swt = 1'b1; tick(); ctl_str = 1'b0; ctl_swt = 1'b0;
            chk("rnd_evt_trg", evt_trg, 1);
            run_until_idle(2000, 1'b1);
            chk("rnd_idle_run", sts_run, 0);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
